dro_pulse_driver: RTL

- Clocked writer/reader for one basic DRO channel with toggle-encoded pulses: every edge, rising or falling, is one pulse.
- Takes a WIDTH-bit word over valid/ready and writes it LSB-first as set pulses, one bit per read cycle.
- Issues a reset pulse for each bit and captures the out pulse that comes back.
- Returns the read-back word with a mismatch flag. Used as the digital-side stimulus and checker that drives DRO cells in mixed testbenches.

---
 rtl/dro_drv_pkg.sv | 23 ++
 rtl/dro_toggle_detect.sv | 30 +++
 rtl/dro_pulse_driver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dro_drv_pkg.sv
// Shared types and defaults for the DRO pulse driver: FSM state encoding,
// default timing constants and the error-counter width.
package dro_drv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SET  = 3'd1,
        ST_HOLD = 3'd2,
        ST_READ = 3'd3,
        ST_CAPT = 3'd4,
        ST_DONE = 3'd5
    } drv_state_e;

    localparam int HOLD_CYC_DEF = 3;
    localparam int RESP_CYC_DEF = 6;
    localparam int SYNC_STG_DEF = 2;
    localparam int ERR_CNT_W    = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dro_toggle_detect.sv
// Synchronizes the asynchronous toggle-encoded DRO out line and flags every
// transition (rising or falling) as a one-cycle pulse.
module dro_toggle_detect
#(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic toggle
);

    logic [SYNC_STG-1:0] sync_q;
    logic                prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], din};
            prev_q <= sync_q[SYNC_STG-1];
        end
    end

    assign toggle = sync_q[SYNC_STG-1] ^ prev_q;

endmodule

// File: rtl/dro_pulse_driver.sv
// Writes a word LSB-first into a DRO channel as toggle-encoded set/reset
// pulses and reads it back. Optional error counter: DRO_DRV_STATS_EN.
module dro_pulse_driver
    import dro_drv_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int RESP_CYC = RESP_CYC_DEF,
    parameter int SYNC_STG = SYNC_STG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             set_o,
    output logic             reset_o,
    input  logic             out_i,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             mismatch,
    output logic             spurious
`ifdef DRO_DRV_STATS_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] SET  = ST_SET;
    localparam logic [2:0] HOLD = ST_HOLD;
    localparam logic [2:0] READ = ST_READ;
    localparam logic [2:0] CAPT = ST_CAPT;
    localparam logic [2:0] DONE = ST_DONE;

    localparam int CNT_MAX = max_int(HOLD_CYC, RESP_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 2);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

    // With a one-cycle hold the HOLD state has nothing to count.
    localparam logic [2:0] AFTER_SET = (HOLD_CYC > 1) ? HOLD : READ;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("dro_pulse_driver: WIDTH must be 1..32");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("dro_pulse_driver: HOLD_CYC must be at least 1");
    end
    if (RESP_CYC < HOLD_CYC) begin : g_bad_resp
        $error("dro_pulse_driver: RESP_CYC must be >= HOLD_CYC for reset-to-set hold");
    end
    if (SYNC_STG < 2) begin : g_bad_sync
        $error("dro_pulse_driver: SYNC_STG must be at least 2");
    end

    logic [2:0]       state;
    logic [BIT_W-1:0] bit_idx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word_q;
    logic             seen_q;
    logic             out_toggle;

    dro_toggle_detect #(
        .SYNC_STG (SYNC_STG)
    ) u_out_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (out_i),
        .toggle (out_toggle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_idx <= '0;
            cnt     <= '0;
            shift_q <= '0;
            word_q  <= '0;
            rd_data <= '0;
            seen_q  <= 1'b0;
            set_o   <= 1'b0;
            reset_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_valid) begin
                        shift_q <= wr_data;
                        word_q  <= wr_data;
                        rd_data <= '0;
                        bit_idx <= '0;
                        cnt     <= '0;
                        state   <= SET;
                    end
                end
                SET: begin
                    // A zero bit is written by the absence of a set edge.
                    if (shift_q[0]) set_o <= ~set_o;
                    cnt   <= '0;
                    state <= AFTER_SET;
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= READ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    reset_o <= ~reset_o;
                    seen_q  <= 1'b0;
                    cnt     <= '0;
                    state   <= CAPT;
                end
                CAPT: begin
                    if (out_toggle && !seen_q) begin
                        rd_data[bit_idx] <= 1'b1;
                        seen_q           <= 1'b1;
                    end
                    if (cnt == RESP_LAST) begin
                        cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift_q <= shift_q >> 1;
                            state   <= SET;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (rd_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Any out edge outside the capture window, or a repeat inside it, is an
    // anomaly of the cell under test; only a full reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spurious <= 1'b0;
        end else if (out_toggle && (state != CAPT || seen_q)) begin
            spurious <= 1'b1;
        end
    end

    assign wr_ready = (state == IDLE);
    assign rd_valid = (state == DONE);
    assign mismatch = rd_valid && (rd_data != word_q);

`ifdef DRO_DRV_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (rd_valid && rd_ready && mismatch && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule
